// File: rtl/led_mux_scanner.sv
// Time-multiplexes LEDS[20:0] onto 7 shared RGB data lines and 3 one-hot group selects.
// Each group gets BLANK dead cycles and then DWELL drive cycles. LEDS is snapshotted once per frame.
module led_mux_scanner #(
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] LEDS,
  input  logic        EN,
  output logic [6:0]  led_rgb_multiplex_a,
  output logic [2:0]  led_rgb_multiplex_b,
  output logic        frame_start
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

  // With no blanking, each group is followed directly by the next group's drive phase.
  localparam state_t ST_GAP = (BLANK == 0) ? ST_DRIVE : ST_BLANK;

  state_t          state_reg, state_next;
  logic [1:0]      group_reg, group_next;
  logic [CW-1:0]   counter_reg, counter_next;
  logic [20:0]     shadow_reg, shadow_next;
  logic [6:0]      a_reg, a_next;
  logic [2:0]      b_reg, b_next;
  logic            frame_start_reg, frame_start_next;
  logic [6:0]      group_data [0:3];
  logic            unused_leds;

  assign unused_leds = &{1'b0, LEDS[31:21]};

  // The slices come from the next shadow value, so a new snapshot reaches the pins immediately.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slice
    assign group_data[gi] = shadow_next[7*gi +: 7];
  end
  assign group_data[3] = 7'd0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg       <= ST_IDLE;
      group_reg       <= 2'd0;
      counter_reg     <= '0;
      shadow_reg      <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      group_reg       <= group_next;
      counter_reg     <= counter_next;
      shadow_reg      <= shadow_next;
      a_reg           <= a_next;
      b_reg           <= b_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    group_next       = group_reg;
    counter_next     = counter_reg + CW'(1);
    shadow_next      = shadow_reg;
    frame_start_next = 1'b0;
    if (!EN) begin
      state_next   = ST_IDLE;
      group_next   = 2'd0;
      counter_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next       = ST_GAP;
          group_next       = 2'd0;
          counter_next     = '0;
          shadow_next      = LEDS[20:0];
          frame_start_next = 1'b1;
        end
        ST_BLANK: begin
          if (counter_reg == BLANK_LAST) begin
            state_next   = ST_DRIVE;
            counter_next = '0;
          end
        end
        ST_DRIVE: begin
          if (counter_reg == DWELL_LAST) begin
            state_next   = ST_GAP;
            counter_next = '0;
            if (group_reg == 2'd2) begin
              group_next       = 2'd0;
              shadow_next      = LEDS[20:0];
              frame_start_next = 1'b1;
            end else begin
              group_next = group_reg + 2'd1;
            end
          end
        end
        default: begin
          state_next   = ST_IDLE;
          group_next   = 2'd0;
          counter_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    a_next = '0;
    b_next = '0;
    if (state_next == ST_DRIVE) begin
      a_next = group_data[group_next];
      b_next = 3'b001 << group_next;
    end
  end

  assign led_rgb_multiplex_a = a_reg;
  assign led_rgb_multiplex_b = b_reg;
  assign frame_start         = frame_start_reg;

endmodule
